// File: rtl/x7seg_scan_if.sv
// x7seg_scan_if: control/data and pin bundle between board logic and the seven-segment scanner.
interface x7seg_scan_if #(parameter int DIGITS = 4);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic                  blank_en;
  logic [3:0]            bright;
  logic [6:0]            a_to_g;
  logic                  dp_n;
  logic [DIGITS-1:0]     an;
  logic                  busy;
  modport master (output load, data, dp, blank_en, bright, input a_to_g, dp_n, an, busy);
  modport slave  (input load, data, dp, blank_en, bright, output a_to_g, dp_n, an, busy);
endinterface

// File: rtl/x7seg_scan.sv
// x7seg_scan: multiplexed seven-segment driver with blanking, dp and PWM brightness.
// Define X7SEG_BCD_EN to add a sequential double-dabble binary-to-BCD converter.
module x7seg_scan #(
  parameter int DIGITS = 4,
  parameter int SCAN_W = 18
) (
  input logic         clk,
  input logic         clr_n,
  x7seg_scan_if.slave io
);
  localparam int W  = 4*DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [SCAN_W-1:0] pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      disp_q, disp_d;
  logic [DIGITS-1:0] dpr_q, dpr_d, an_q, an_d, blank;
  logic [6:0]        seg_q, seg_d;
  logic              dpn_q, dpn_d, ovf_q, ovf_d, lit, zero;
  logic [3:0]        nib;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

`ifdef X7SEG_BCD_EN
  localparam int CW = $clog2(W);
  localparam logic [32:0] LIM = 33'(10**DIGITS);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [W-1:0]      bin_q, bin_d, bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIGITS-1:0] dpp_q, dpp_d;
  logic              ovp_q, ovp_d;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dpp_d   = dpp_q;
    ovp_d   = ovp_q;
    disp_d  = disp_q;
    dpr_d   = dpr_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (io.load) begin
        state_d = SHIFT;
        bin_d   = io.data;
        bcd_d   = '0;
        cnt_d   = '0;
        dpp_d   = io.dp;
        ovp_d   = 33'(io.data) >= LIM;
      end
    end else begin
      bcd_d = W'({adj, bin_q[W-1]});
      bin_d = bin_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W-1)) begin
        state_d = IDLE;
        disp_d  = bcd_d;
        dpr_d   = dpp_q;
        ovf_d   = ovp_q;
      end
    end
  end
  // Reset aborts any conversion in flight; the pending result is simply discarded.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dpp_q   <= '0;
      ovp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dpp_q   <= dpp_d;
      ovp_q   <= ovp_d;
    end
  end
  assign io.busy = state_q == SHIFT;
`else
  always_comb begin
    disp_d = io.load ? io.data : disp_q;
    dpr_d  = io.load ? io.dp : dpr_q;
    ovf_d  = 1'b0;
  end
  assign io.busy = 1'b0;
`endif

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = &pre_q ? (idx_q == IW'(DIGITS-1) ? '0 : idx_q + 1'b1) : idx_q;
    nib   = disp_q[4*idx_q +: 4];
    zero  = 1'b1;
    blank = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      zero     = zero & (disp_q[4*i +: 4] == 4'd0);
      blank[i] = (i > 0) && zero && io.blank_en && !ovf_q;
    end
    lit   = (pre_q[SCAN_W-1 -: 4] <= io.bright) && !blank[idx_q];
    an_d  = '1;
    an_d[idx_q] = !lit;
    seg_d = !lit ? 7'h7f : ovf_q ? 7'b1111110 : seg7(nib);
    dpn_d = !lit || !dpr_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pre_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      dpr_q  <= '0;
      ovf_q  <= 1'b0;
      an_q   <= '1;
      seg_q  <= 7'h7f;
      dpn_q  <= 1'b1;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      dpr_q  <= dpr_d;
      ovf_q  <= ovf_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dpn_q  <= dpn_d;
    end
  end

  assign io.an     = an_q;
  assign io.a_to_g = seg_q;
  assign io.dp_n   = dpn_q;
endmodule

// File: tb/tb_x7seg_scan.sv
// tb_x7seg_scan: directed checks of scan order, blanking, brightness and (with X7SEG_BCD_EN) conversion.
module tb_x7seg_scan;
  logic clk = 1'b0;
  logic clr_n;
  int   t, n_chk, n_fail, cnt;
  x7seg_scan_if #(.DIGITS(4)) io ();
  x7seg_scan #(.DIGITS(4), .SCAN_W(4)) dut (.clk(clk), .clr_n(clr_n), .io(io));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int n);
    while (t < n) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pins(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dpn);
    chk({tag, "_an"}, 16'(io.an), 16'(an));
    chk({tag, "_seg"}, 16'(io.a_to_g), 16'(seg));
    chk({tag, "_dpn"}, 16'(io.dp_n), 16'(dpn));
  endtask

  task automatic load_at(input int when, input logic [15:0] d, input logic [3:0] p);
    run_to(when);
    io.data = d;
    io.dp   = p;
    io.load = 1'b1;
    tick();
    io.load = 1'b0;
  endtask

  initial begin
    t = 0; n_chk = 0; n_fail = 0;
    clr_n = 1'b0; io.load = 1'b1; io.data = 16'h1234; io.dp = 4'hF;
    io.blank_en = 1'b0; io.bright = 4'd15;
    repeat (3) tick();
    t = 0;
    clr_n = 1'b1; io.load = 1'b0; io.dp = 4'h0;
    pins("reset", 4'b1111, 7'h7f, 1'b1);
    chk("reset_busy", 16'(io.busy), 16'h0);
    tick();
    pins("first", 4'b1110, 7'b0000001, 1'b1);
    // Brightness: digit1 slot covers t=17..32, digit2 slot t=33..48
    run_to(16);
    io.bright = 4'd0;
    cnt = 0;
    repeat (16) begin tick(); if (io.an != 4'b1111) cnt++; if (t == 17) chk("b0_an", 16'(io.an), 16'b1101); end
    chk("bright0_count", 16'(cnt), 16'd1);
    io.bright = 4'd7;
    cnt = 0;
    repeat (16) begin
      tick();
      if (io.an != 4'b1111) cnt++;
      if (t == 40) chk("b7_on", 16'(io.an), 16'b1011);
      if (t == 41) chk("b7_off", 16'(io.an), 16'b1111);
    end
    chk("bright7_count", 16'(cnt), 16'd8);
    io.bright = 4'd15;
`ifdef X7SEG_BCD_EN
    load_at(48, 16'd1234, 4'h0);
    chk("bcd_busy_start", 16'(io.busy), 16'h1);
    cnt = 1;
    while (t < 70) begin
      if (t == 52) begin io.data = 16'd9999; io.load = 1'b1; end
      else if (t == 64) begin io.data = 16'd9999; io.load = 1'b1; end
      else io.load = 1'b0;
      tick();
      if (io.busy) cnt++;
      if (t == 64) chk("bcd_busy_last", 16'(io.busy), 16'h1);
      if (t == 65) chk("bcd_busy_fall", 16'(io.busy), 16'h0);
    end
    io.load = 1'b0;
    chk("bcd_busy_len", 16'(cnt), 16'd16);
    run_to(70);  pins("bcd_d0", 4'b1110, 7'b1001100, 1'b1);
    run_to(85);  pins("bcd_d1", 4'b1101, 7'b0000110, 1'b1);
    run_to(100); pins("bcd_d2", 4'b1011, 7'b0010010, 1'b1);
    run_to(120); pins("bcd_d3", 4'b0111, 7'b1001111, 1'b1);
    io.blank_en = 1'b1;
    load_at(128, 16'd10000, 4'b0010);
    run_to(150); pins("ovf_d1", 4'b1101, 7'b1111110, 1'b0);
    run_to(165); pins("ovf_d2", 4'b1011, 7'b1111110, 1'b1);
    run_to(180); pins("ovf_d3", 4'b0111, 7'b1111110, 1'b1);
    run_to(195); pins("ovf_d0", 4'b1110, 7'b1111110, 1'b1);
    load_at(200, 16'd42, 4'h0);
    run_to(205);
    chk("mid_busy", 16'(io.busy), 16'h1);
    clr_n = 1'b0;
    tick();
    t = 0;
    clr_n = 1'b1;
    chk("abort_busy", 16'(io.busy), 16'h0);
    pins("abort_pins", 4'b1111, 7'h7f, 1'b1);
    io.blank_en = 1'b0;
    run_to(5);  pins("abort_d0", 4'b1110, 7'b0000001, 1'b1);
    run_to(20); pins("abort_d1", 4'b1101, 7'b0000001, 1'b1);
    run_to(40);
    chk("abort_idle", 16'(io.busy), 16'h0);
`else
    load_at(48, 16'hA5C3, 4'b0100);
    chk("hex_busy", 16'(io.busy), 16'h0);
    run_to(70);  pins("hex_d0", 4'b1110, 7'b0000110, 1'b1);
    run_to(80);  pins("hex_d0_end", 4'b1110, 7'b0000110, 1'b1);
    run_to(81);  pins("hex_d1", 4'b1101, 7'b0110001, 1'b1);
    run_to(100); pins("hex_d2", 4'b1011, 7'b0100100, 1'b0);
    run_to(120); pins("hex_d3", 4'b0111, 7'b0001000, 1'b1);
    run_to(130); pins("hex_wrap", 4'b1110, 7'b0000110, 1'b1);
    io.blank_en = 1'b1;
    load_at(130, 16'h0070, 4'b0100);
    run_to(140); pins("blk_d0", 4'b1110, 7'b0000001, 1'b1);
    run_to(150); pins("blk_d1", 4'b1101, 7'b0001111, 1'b1);
    run_to(165); pins("blk_d2", 4'b1111, 7'h7f, 1'b1);
    run_to(180); pins("blk_d3", 4'b1111, 7'h7f, 1'b1);
    load_at(180, 16'h0000, 4'b0000);
    run_to(200); pins("zero_d0", 4'b1110, 7'b0000001, 1'b1);
    run_to(215); pins("zero_d1", 4'b1111, 7'h7f, 1'b1);
    run_to(230); pins("zero_d2", 4'b1111, 7'h7f, 1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/x7seg_scan.md
# x7seg_scan

Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit scanner. Captures a display word on a load strobe, scans DIGITS common-anode digits with a power-of-two slot timer, and adds leading-zero blanking, per-digit decimal points and 16-level PWM brightness. An optional sequential binary-to-BCD converter lets the block show unsigned binary values in decimal. It sits between board-level control logic and the FPGA display pins.

## Interface
- DIGITS, 4, number of multiplexed digits (1..8)
- SCAN_W, 18, each digit slot lasts 2^SCAN_W clk cycles (SCAN_W >= 4)
- clk  input  1  system clock; all logic is on its rising edge
- clr_n  input  1  reset, synchronous and active-low
- load  input  1  capture strobe for data/dp; accepted only when busy=0
- data  input  4*DIGITS  display value: hex nibbles, or unsigned binary with X7SEG_BCD_EN; nibble 0 = rightmost digit
- dp  input  DIGITS  decimal-point enables, captured with data
- blank_en  input  1  leading-zero blanking enable (live, not captured)
- bright  input  4  brightness level, 0 = 1/16 duty, 15 = full (live)
- a_to_g  output  7  segments a..g, bit 6 = a, active-low, registered
- dp_n  output  1  decimal point, active-low, registered
- an  output  DIGITS  digit anodes, active-low, one-hot-low or all high, registered
- busy  output  1  conversion in progress; load is ignored while high

## Operation
- Display register disp (4*DIGITS bits) and dp register dpr are captured on an accepted load. Without BCD, disp <= data and dpr <= dp on the load edge.
- Scan: prescaler pre (SCAN_W bits) increments every cycle and wraps. When pre reaches all-ones, the digit index idx advances on the next edge: DIGITS-1 wraps to 0. idx 0 drives an[0].
- Brightness: phase = pre[SCAN_W-1:SCAN_W-4]. The digit is lit only while phase <= bright.
- Blanking: digit i (i>0) is blank when blank_en=1 and nibbles i..DIGITS-1 of disp are all zero. Digit 0 is never blanked. A blank digit holds its anode high, including its dp.
- Segment code, active-low, a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. Dash = 1111110.
- When a digit is unlit: an bit = 1, a_to_g = 1111111, dp_n = 1.
- Reset (clr_n=0 at an edge): pre=0, idx=0, disp=0, dpr=0, busy=0, an=all 1, a_to_g=1111111, dp_n=1. A reset during a conversion aborts it. Reset dominates load.

## Timing
- Output latency: an, a_to_g and dp_n are registered one cycle after idx, pre and disp.
- Hex mode: a load at edge N takes effect on disp at edge N, and the pins reflect it at edge N+1. busy stays 0.
- BCD mode: a load accepted at edge N sets busy=1 from edge N. Busy stays high for exactly 4*DIGITS cycles. disp is written on the edge where busy falls.
- FSM states: IDLE, SHIFT. IDLE goes to SHIFT on an accepted load. SHIFT goes to IDLE after 4*DIGITS shift-add-3 iterations, one per cycle.
- A load asserted while busy=1, including the final busy cycle, is dropped and not queued.
- The old display keeps scanning during a conversion.

## Configuration
- X7SEG_BCD_EN defined: data is unsigned binary. Conversion uses sequential double-dabble into DIGITS BCD nibbles.
  - If data >= 10^DIGITS (compared at load), the conversion still takes the full latency, then every digit shows dash. In overflow, blanking is suppressed and dp is still honoured.
- X7SEG_BCD_EN undefined: there is no converter or FSM. Hex mode applies, busy is tied 0, and dash is never produced.

## Test plan
- Reset: hold clr_n=0 for 3 cycles with load=1 and data=16'h1234 -> an=1111, a_to_g=1111111, dp_n=1, busy=0. After release, the first digit shows 0 on an[0].
- Hex scan (SCAN_W=4, bright=15, blank_en=0): load data=16'hA5C3, dp=4'b0100 -> each digit lasts 16 cycles in order an[0..3]: 3, C, 5, A. dp_n=0 only while an[2]=0. idx wraps 3 -> 0.
- Blanking: load 16'h0070 with blank_en=1 -> digits 3 and 2 never lit, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 -> only digit 0 lit, showing 0.
- Brightness (SCAN_W=4): bright=0 -> each anode low for exactly 1 of 16 slot cycles. bright=7 -> low for 8 of 16.
- BCD (macro on, DIGITS=4): load 16'd1234 -> busy high exactly 16 cycles. Display then shows 1,2,3,4. A load during busy is ignored.
  - Load 16'd10000 -> all four digits show dash.
- Reset mid-conversion: clr_n=0 on busy cycle 5 -> busy=0 next cycle. disp=0, and no late update occurs.
